bcd_score_accumulator: RTL and testbench
========================================

Name: bcd_score_accumulator

Overview:
- Multi-digit BCD score register that sits directly downstream of the game's scoring-event logic and upstream of the hex display drivers.
- Accepts one signed per-event delta at a time and adds it to the least-significant BCD digit.
- Ripples the resulting decimal carry or borrow upward one digit per clock.
- Publishes a stable, saturated score to the displays only when an update is complete.

Parameters:
- DIGITS, 4, number of BCD digits held (>=2); score range 0 .. 10^DIGITS-1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous clear of the score to zero.
- delta_valid  input  1  delta presented this cycle.
- delta  input  5  two's-complement score change; legal range -8..+8.
- ready  output  1  block can accept a delta this cycle.
- score  output  4*DIGITS  committed BCD score; digit i is bits [4i+3:4i], digit 0 is least significant.
- updated  output  1  one-cycle pulse: score changed by a delta commit this cycle.
- overflow  output  1  one-cycle pulse: result exceeded maximum and was clamped to all 9s.
- underflow  output  1  one-cycle pulse: result went below zero and was clamped to 0.

Behaviour:
- Reset (async, active-high): score=0, internal working digits=0, state=IDLE, ready=1, updated=overflow=underflow=0.
- Internal state: working register of DIGITS BCD digits, carry register in {-1,0,+1}, digit index, FSM {IDLE, RIPPLE}.
- Digit arithmetic, for a value d in 0..9 plus increment n:
  - s = d + n, computed as 6-bit signed.
  - s<0: digit = s+10, carry -1.
  - s>9: digit = s-10, carry +1.
  - otherwise: digit = s, carry 0.
- IDLE:
  - ready=1.
  - Handshake: a delta is accepted on any edge where delta_valid=1 and ready=1.
  - A delta outside -8..+8 is accepted and treated as 0; it causes a commit with an unchanged value and updated=1.
  - At the accepting edge: working digit 0 <= digit-0 result of the delta.
  - If that carry is 0: commit at the same edge.
  - Otherwise: store the carry, index <= 1, go to RIPPLE.
- RIPPLE:
  - ready=0.
  - Each edge applies the stored carry to working digit[index].
  - If the new carry is 0: commit, go to IDLE.
  - If the new carry is nonzero and index < DIGITS-1: store the carry, index++.
  - If index = DIGITS-1 and the carry is still nonzero, saturate:
    - +1 carry: working and score <= all 9s, overflow=1.
    - -1 carry: working and score <= all 0s, underflow=1.
    - Return to IDLE.
- Commit: score <= working result, updated=1 for exactly that cycle. score never shows a partially rippled value.
- Latency:
  - No carry: score valid 1 edge after acceptance.
  - Ripple through k further digits: 1+k edges.
  - Worst case: DIGITS edges.
  - ready reasserts in the cycle after the commit edge.
- delta_valid while ready=0 is ignored (not queued). The producer holds delta_valid until ready.
- clear=1 at an edge:
  - score, working <= 0; FSM -> IDLE; stored carry discarded.
  - No updated/overflow/underflow pulse.
  - clear has priority over an accept in the same cycle; that delta is dropped.
- Pulses updated, overflow and underflow are registered, deassert the next cycle, and are mutually exclusive except that overflow/underflow coincide with updated=1.
- Reset asserted mid-ripple: immediate return to reset values regardless of clk.

Test Plan:
- DIGITS=4, reset, then delta=+5 at score 0000 -> one edge later score=0005, updated pulses once, ready high throughout.
- Score 0199, delta=+3 -> digit0=2, carries ripple 2 digits; ready low 2 cycles; score jumps 0199->0202 at edge 3, never shows 0192/0102.
- Score 9998, delta=+5 -> ripple to top, score=9999, overflow=1 and updated=1 for one cycle, ready back next cycle.
- Score 0003, delta=-8 (5'b11000) -> score=0000, underflow pulse; then delta=-2 from 0010 -> 0008, borrow path, no underflow.
- Score 0999, delta=+1 accepted, then clear=1 during RIPPLE -> score=0000, no updated pulse; a delta_valid held during RIPPLE is ignored until ready=1.
- Assert reset asynchronously (between edges) mid-ripple from 0999+1 -> score=0000, ready=1 immediately; delta=+12 afterwards -> accepted as 0, score unchanged, updated pulses.

Source files
------------

// File: rtl/bcd_score_accumulator.sv
// Signed-delta BCD score register: adds a delta to digit 0, ripples the decimal
// carry/borrow one digit per clock, and publishes a saturated score on commit.
module bcd_score_accumulator #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  delta_valid,
  input  logic [4:0]            delta,
  output logic                  ready,
  output logic [4*DIGITS-1:0]   score,
  output logic                  updated,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = $clog2(DIGITS);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_RIPPLE = 1'b1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef struct packed {
    logic signed [1:0] carry;
    logic [3:0]        digit;
  } digit_res_t;

  function automatic digit_res_t digit_add(input logic [3:0] d, input logic signed [5:0] n);
    logic signed [5:0] s;
    logic signed [5:0] t;
    digit_res_t        r;
    s = $signed({2'b00, d}) + n;
    if (s < 6'sd0) begin
      t       = s + 6'sd10;
      r.digit = t[3:0];
      r.carry = -2'sd1;
    end else if (s > 6'sd9) begin
      t       = s - 6'sd10;
      r.digit = t[3:0];
      r.carry = 2'sd1;
    end else begin
      r.digit = s[3:0];
      r.carry = 2'sd0;
    end
    return r;
  endfunction

  logic [0:0]        state_q, state_d;
  logic [W-1:0]      working_q, working_d;
  logic signed [1:0] carry_q, carry_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [W-1:0]      score_q, score_d;
  logic              updated_q, updated_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic signed [5:0] delta_ext;
  logic signed [5:0] inc;
  digit_res_t        res0;
  digit_res_t        resr;
  logic [W-1:0]      all_nines;

  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      all_nines[4*i +: 4] = 4'd9;
    end
  end

  // Out-of-range deltas still go through the handshake, but as a zero change.
  assign delta_ext = $signed({delta[4], delta});
  assign inc       = (delta_ext >= -6'sd8 && delta_ext <= 6'sd8) ? delta_ext : 6'sd0;
  assign res0      = digit_add(working_q[3:0], inc);
  assign resr      = digit_add(working_q[idx_q*4 +: 4], $signed({{4{carry_q[1]}}, carry_q}));

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    working_d   = working_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    score_d     = score_q;
    updated_d   = 1'b0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;

    if (clear) begin
      state_d   = S_IDLE;
      working_d = '0;
      carry_d   = 2'sd0;
      idx_d     = '0;
      score_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (delta_valid) begin
            working_d[3:0] = res0.digit;
            if (res0.carry == 2'sd0) begin
              score_d   = working_d;
              updated_d = 1'b1;
            end else begin
              carry_d = res0.carry;
              idx_d   = IDX_W'(1);
              state_d = S_RIPPLE;
            end
          end
        end
        S_RIPPLE: begin
          working_d[idx_q*4 +: 4] = resr.digit;
          if (resr.carry == 2'sd0) begin
            score_d   = working_d;
            updated_d = 1'b1;
            carry_d   = 2'sd0;
            state_d   = S_IDLE;
          end else if (idx_q != LAST_IDX) begin
            carry_d = resr.carry;
            idx_d   = idx_q + 1'b1;
          end else begin
            // Carry out of the top digit: clamp rather than wrap.
            working_d  = (resr.carry > 2'sd0) ? all_nines : '0;
            score_d    = working_d;
            updated_d  = 1'b1;
            overflow_d = (resr.carry > 2'sd0);
            underflow_d = (resr.carry < 2'sd0);
            carry_d    = 2'sd0;
            state_d    = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      working_q   <= '0;
      carry_q     <= 2'sd0;
      idx_q       <= '0;
      score_q     <= '0;
      updated_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      working_q   <= working_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      score_q     <= score_d;
      updated_q   <= updated_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign score     = score_q;
  assign updated   = updated_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_bcd_score_accumulator.sv
// Directed bench for bcd_score_accumulator: vector table of single deltas from a
// preloaded score, plus hand sequences for clear, ignored valid and async reset.
module tb_bcd_score_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        delta_valid;
  logic [4:0]  delta;
  logic        ready;
  logic [15:0] score;
  logic        updated;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  bcd_score_accumulator #(.DIGITS(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .delta_valid (delta_valid),
    .delta       (delta),
    .ready       (ready),
    .score       (score),
    .updated     (updated),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] start;
    logic [4:0]  delta;
    logic [15:0] exp_score;
    int          exp_lat;
    logic        exp_ovf;
    logic        exp_unf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] b);
    return b[15:12] * 1000 + b[11:8] * 100 + b[7:4] * 10 + b[3:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_quiet(input int step);
    int n;
    delta_valid = 1'b1;
    delta       = 5'(step);
    tick();
    delta_valid = 1'b0;
    n = 0;
    while (!updated && n < 10) begin
      tick();
      n++;
    end
    if (!updated) check("load_timeout", {31'd0, updated}, 32'd1);
  endtask

  task automatic load(input logic [15:0] bcd);
    int target;
    int total;
    int step;
    target = bcd2int(bcd);
    total  = 0;
    clear  = 1'b1;
    tick();
    clear  = 1'b0;
    while (total < target) begin
      step = (target - total > 8) ? 8 : target - total;
      add_quiet(step);
      total += step;
    end
    tick();
    check("load_score", {16'd0, score}, {16'd0, bcd});
  endtask

  // Present one delta from IDLE and check latency, frozen score during ripple and flags.
  task automatic run_delta(input string tag, input logic [15:0] start, input logic [4:0] d,
                           input logic [15:0] exp_score, input int exp_lat,
                           input logic exp_ovf, input logic exp_unf);
    int lat;
    check({tag, "_ready_in"}, {31'd0, ready}, 32'd1);
    delta_valid = 1'b1;
    delta       = d;
    tick();
    delta_valid = 1'b0;
    lat = 1;
    while (!updated && lat < 10) begin
      check({tag, "_ready_low"}, {31'd0, ready}, 32'd0);
      check({tag, "_score_frozen"}, {16'd0, score}, {16'd0, start});
      tick();
      lat++;
    end
    check({tag, "_score"}, {16'd0, score}, {16'd0, exp_score});
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_updated"}, {31'd0, updated}, 32'd1);
    check({tag, "_overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
    check({tag, "_underflow"}, {31'd0, underflow}, {31'd0, exp_unf});
    tick();
    check({tag, "_updated_drop"}, {29'd0, updated, overflow, underflow}, 32'd0);
    check({tag, "_ready_back"}, {31'd0, ready}, 32'd1);
    check({tag, "_score_hold"}, {16'd0, score}, {16'd0, exp_score});
  endtask

  initial begin
    vecs[0] = '{16'h0000, 5'd5,      16'h0005, 1, 1'b0, 1'b0};
    vecs[1] = '{16'h0199, 5'd3,      16'h0202, 3, 1'b0, 1'b0};
    vecs[2] = '{16'h9998, 5'd5,      16'h9999, 4, 1'b1, 1'b0};
    vecs[3] = '{16'h0003, 5'b11000,  16'h0000, 4, 1'b0, 1'b1};
    vecs[4] = '{16'h0010, 5'b11110,  16'h0008, 2, 1'b0, 1'b0};
    vecs[5] = '{16'h1234, 5'd12,     16'h1234, 1, 1'b0, 1'b0};
    vecs[6] = '{16'h1234, 5'b10111,  16'h1234, 1, 1'b0, 1'b0};
    vecs[7] = '{16'h9999, 5'd1,      16'h9999, 4, 1'b1, 1'b0};
    vecs[8] = '{16'h0500, 5'b11111,  16'h0499, 3, 1'b0, 1'b0};
    vecs[9] = '{16'h0042, 5'd8,      16'h0050, 2, 1'b0, 1'b0};

    reset       = 1'b1;
    clear       = 1'b0;
    delta_valid = 1'b0;
    delta       = 5'd0;
    #12;
    reset = 1'b0;
    tick();
    check("reset_score", {16'd0, score}, 32'd0);
    check("reset_ready", {31'd0, ready}, 32'd1);
    check("reset_pulses", {29'd0, updated, overflow, underflow}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      load(vecs[i].start);
      run_delta($sformatf("vec%0d", i), vecs[i].start, vecs[i].delta, vecs[i].exp_score,
                vecs[i].exp_lat, vecs[i].exp_ovf, vecs[i].exp_unf);
    end

    // Clear during ripple wins over a held delta and discards the pending carry.
    load(16'h0999);
    delta_valid = 1'b1;
    delta       = 5'd1;
    tick();
    check("clr_in_ripple", {31'd0, ready}, 32'd0);
    delta = 5'd2;
    clear = 1'b1;
    tick();
    clear       = 1'b0;
    delta_valid = 1'b0;
    check("clr_score", {16'd0, score}, 32'd0);
    check("clr_pulses", {29'd0, updated, overflow, underflow}, 32'd0);
    check("clr_ready", {31'd0, ready}, 32'd1);
    tick();
    tick();
    check("clr_no_resume", {15'd0, updated, score}, 32'd0);

    // A valid held through ripple is only taken once ready returns.
    load(16'h0999);
    delta_valid = 1'b1;
    delta       = 5'd1;
    tick();
    delta = 5'd2;
    tick();
    tick();
    check("hold_mid_score", {16'd0, score}, 32'h0999);
    tick();
    check("hold_commit1", {15'd0, updated, score}, {15'd0, 1'b1, 16'h1000});
    tick();
    delta_valid = 1'b0;
    check("hold_commit2", {15'd0, updated, score}, {15'd0, 1'b1, 16'h1002});
    tick();

    // Asynchronous reset between edges mid-ripple.
    load(16'h0999);
    delta_valid = 1'b1;
    delta       = 5'd1;
    tick();
    delta_valid = 1'b0;
    check("arst_pre_ready", {31'd0, ready}, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("arst_score", {16'd0, score}, 32'd0);
    check("arst_ready", {31'd0, ready}, 32'd1);
    #2;
    reset = 1'b0;
    tick();
    check("arst_idle", {15'd0, ready, score}, 32'h0001_0000);
    run_delta("arst_plus12", 16'h0000, 5'd12, 16'h0000, 1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
